// File: rtl/jelly2_necolink_frame_generator.sv
// rtl/jelly2_necolink_frame_generator.sv - NecoLink frame generator: preamble, SFD, optional MAC header, node/type/length, payload, CRC-32 FCS, inter-frame gap
module jelly2_necolink_frame_generator #(
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_LEN      = 12,
    parameter int LENGTH_BITS  = 16,
    parameter bit DEBUG        = 1'b0,
    parameter bit SIMULATION   = 1'b0
) (
    input  logic                   reset,
    input  logic                   clk,
    input  logic                   cke,
    input  logic                   start,
    output logic                   busy,
    input  logic                   param_mac_enable,
    input  logic [47:0]            param_mac_dst,
    input  logic [47:0]            param_mac_src,
    input  logic [15:0]            param_mac_type,
    input  logic [7:0]             param_node,
    input  logic [7:0]             param_type,
    input  logic [LENGTH_BITS-1:0] param_length,
    input  logic [7:0]             s_payload_data,
    input  logic                   s_payload_valid,
    output logic                   s_payload_ready,
    output logic [7:0]             m_data,
    output logic                   m_first,
    output logic                   m_last,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   packet_start,
    output logic                   packet_finish
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_PREAMBLE, ST_SFD, ST_MAC_DST, ST_MAC_SRC, ST_MAC_TYPE,
        ST_NODE, ST_TYPE, ST_LENGTH, ST_PAYLOAD, ST_FCS, ST_GAP
    } state_t;

    state_t          state, next_state;
    logic [15:0]     cnt, next_cnt;
    logic [31:0]     crc, next_crc;
    logic [7:0]      next_data;
    logic            next_valid, next_first, next_last;
    logic            crc_en, latch, adv;

    logic            mac_enable;
    logic [5:0][7:0] mac_dst, mac_src;
    logic [1:0][7:0] mac_type, length;
    logic [7:0]      node, ptype;
    logic [3:0][7:0] fcs;

    function automatic logic [31:0] crc_update(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    assign adv             = cke & (~m_valid | m_ready);
    assign s_payload_ready = adv & (state == ST_PAYLOAD);
    assign busy            = (state != ST_IDLE) | m_valid;
    assign packet_start    = m_valid & m_ready & m_first & cke;
    assign packet_finish   = m_valid & m_ready & m_last & cke;
    assign fcs             = ~crc;

    // state names the byte produced on the next advance; cnt indexes bytes within a field
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_data  = m_data;
        next_valid = 1'b0;
        next_first = 1'b0;
        next_last  = 1'b0;
        crc_en     = 1'b0;
        latch      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_PREAMBLE;
                    next_cnt   = '0;
                    latch      = 1'b1;
                end
            end
            ST_PREAMBLE: begin
                next_data  = 8'h55;
                next_valid = 1'b1;
                next_first = (cnt == 16'd0);
                if (cnt == 16'(PREAMBLE_LEN - 1)) begin
                    next_state = ST_SFD;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + 16'd1;
                end
            end
            ST_SFD: begin
                next_data  = 8'hD5;
                next_valid = 1'b1;
                next_cnt   = '0;
                next_state = mac_enable ? ST_MAC_DST : ST_NODE;
            end
            ST_MAC_DST, ST_MAC_SRC: begin
                next_data  = (state == ST_MAC_DST) ? mac_dst[3'd5 - cnt[2:0]] : mac_src[3'd5 - cnt[2:0]];
                next_valid = 1'b1;
                crc_en     = 1'b1;
                if (cnt == 16'd5) begin
                    next_state = (state == ST_MAC_DST) ? ST_MAC_SRC : ST_MAC_TYPE;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + 16'd1;
                end
            end
            ST_MAC_TYPE: begin
                next_data  = mac_type[~cnt[0]];
                next_valid = 1'b1;
                crc_en     = 1'b1;
                if (cnt == 16'd1) begin
                    next_state = ST_NODE;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + 16'd1;
                end
            end
            ST_NODE: begin
                next_data  = node;
                next_valid = 1'b1;
                crc_en     = 1'b1;
                next_state = ST_TYPE;
            end
            ST_TYPE: begin
                next_data  = ptype;
                next_valid = 1'b1;
                crc_en     = 1'b1;
                next_state = ST_LENGTH;
                next_cnt   = '0;
            end
            ST_LENGTH: begin
                next_data  = length[cnt[0]];
                next_valid = 1'b1;
                crc_en     = 1'b1;
                if (cnt == 16'd1) begin
                    next_cnt   = '0;
                    next_state = (length == 16'd0) ? ST_FCS : ST_PAYLOAD;
                end else begin
                    next_cnt = cnt + 16'd1;
                end
            end
            ST_PAYLOAD: begin
                // an empty upstream cycle becomes an output bubble; the counter holds
                if (s_payload_valid) begin
                    next_data  = s_payload_data;
                    next_valid = 1'b1;
                    crc_en     = 1'b1;
                    if (cnt == length - 16'd1) begin
                        next_state = ST_FCS;
                        next_cnt   = '0;
                    end else begin
                        next_cnt = cnt + 16'd1;
                    end
                end
            end
            ST_FCS: begin
                next_data  = fcs[cnt[1:0]];
                next_valid = 1'b1;
                next_last  = (cnt == 16'd3);
                if (cnt == 16'd3) begin
                    next_cnt   = '0;
                    next_state = (IFG_LEN == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    next_cnt = cnt + 16'd1;
                end
            end
            ST_GAP: begin
                if (cnt == 16'(IFG_LEN)) begin
                    next_state = ST_IDLE;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + 16'd1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
        next_crc = latch ? 32'hFFFFFFFF : (crc_en ? crc_update(crc, next_data) : crc);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            crc     <= 32'hFFFFFFFF;
            m_data  <= '0;
            m_valid <= 1'b0;
            m_first <= 1'b0;
            m_last  <= 1'b0;
        end else if (adv) begin
            state   <= next_state;
            cnt     <= next_cnt;
            crc     <= next_crc;
            m_data  <= next_data;
            m_valid <= next_valid;
            m_first <= next_first;
            m_last  <= next_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && adv && latch) begin
            mac_enable <= param_mac_enable;
            mac_dst    <= param_mac_dst;
            mac_src    <= param_mac_src;
            mac_type   <= param_mac_type;
            node       <= param_node;
            ptype      <= param_type;
            length     <= 16'(param_length);
        end
    end

    if (SIMULATION) begin : g_sim
        always_ff @(posedge clk) begin
            if (!reset) assert (!(m_valid && m_first && m_last));
        end
    end

    if (DEBUG) begin : g_debug
        (* mark_debug = "true" *) logic [3:0]  dbg_state;
        (* mark_debug = "true" *) logic [15:0] dbg_cnt;
        always_ff @(posedge clk) begin
            dbg_state <= state;
            dbg_cnt   <= cnt;
        end
    end

endmodule

// File: tb/tb_jelly2_necolink_frame_generator.sv
// tb/tb_jelly2_necolink_frame_generator.sv - scoreboard bench for jelly2_necolink_frame_generator
module tb_jelly2_necolink_frame_generator;

    localparam int PRE = 7;
    localparam int IFG = 12;
    localparam int LB  = 16;

    logic        reset = 1'b1, clk = 1'b0, cke = 1'b1, start = 1'b0;
    logic        busy;
    logic        p_mac_en = 1'b0;
    logic [47:0] p_dst = '0, p_src = '0;
    logic [15:0] p_mtype = '0;
    logic [7:0]  p_node = '0, p_type = '0;
    logic [15:0] p_len = '0;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  m_data;
    logic        m_first, m_last, m_valid;
    logic        m_ready = 1'b1;
    logic        pkt_s, pkt_f;

    jelly2_necolink_frame_generator #(
        .PREAMBLE_LEN(PRE), .IFG_LEN(IFG), .LENGTH_BITS(LB), .DEBUG(1'b0), .SIMULATION(1'b0)
    ) dut (
        .reset(reset), .clk(clk), .cke(cke), .start(start), .busy(busy),
        .param_mac_enable(p_mac_en), .param_mac_dst(p_dst), .param_mac_src(p_src),
        .param_mac_type(p_mtype), .param_node(p_node), .param_type(p_type), .param_length(p_len),
        .s_payload_data(s_data), .s_payload_valid(s_valid), .s_payload_ready(s_ready),
        .m_data(m_data), .m_first(m_first), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
        .packet_start(pkt_s), .packet_finish(pkt_f)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0;
    logic [9:0]  exp_q[$];
    int          len_q[$];
    logic [7:0]  pay_q[$];
    int          accepts = 0, frames_done = 0, consumed = 0;
    int          rdy_pct = 100, val_pct = 100;
    bit          cke_toggle = 1'b0, fixed_pay = 1'b0, pay_taken = 1'b0, track = 1'b0;
    int          gap_cnt = 0, fbytes = 0;
    logic [31:0] crc_tbl[256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_bytes(input logic [31:0] c_in, input logic [7:0] b);
        return (c_in >> 8) ^ crc_tbl[8'(c_in ^ 32'(b))];
    endfunction

    // reference frame straight from the field layout; the payload is generated here too
    task automatic push_frame();
        logic [7:0]  body[$];
        logic [7:0]  pb;
        logic [31:0] c, f;
        if (p_mac_en) begin
            for (int i = 5; i >= 0; i--) body.push_back(p_dst[8*i +: 8]);
            for (int i = 5; i >= 0; i--) body.push_back(p_src[8*i +: 8]);
            body.push_back(p_mtype[15:8]);
            body.push_back(p_mtype[7:0]);
        end
        body.push_back(p_node);
        body.push_back(p_type);
        body.push_back(p_len[7:0]);
        body.push_back(p_len[15:8]);
        for (int i = 0; i < int'(p_len); i++) begin
            pb = fixed_pay ? 8'(i + 1) : 8'($urandom);
            pay_q.push_back(pb);
            body.push_back(pb);
        end
        c = 32'hFFFFFFFF;
        foreach (body[i]) c = crc_bytes(c, body[i]);
        f = ~c;
        for (int i = 0; i < PRE; i++) exp_q.push_back({(i == 0), 1'b0, 8'h55});
        exp_q.push_back({2'b00, 8'hD5});
        foreach (body[i]) exp_q.push_back({2'b00, body[i]});
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, (i == 3), f[8*i +: 8]});
        len_q.push_back(PRE + 1 + (p_mac_en ? 14 : 0) + 4 + int'(p_len) + 4);
    endtask

    always @(negedge clk) begin
        logic [9:0] e;
        if (reset) begin
            track     = 1'b0;
            fbytes    = 0;
            pay_taken = 1'b0;
        end else begin
            pay_taken = s_valid && s_ready;
            if (pay_taken) consumed++;
            if (!cke) check("ready_while_cke0", 32'(s_ready), 32'd0);
            if (track) begin
                if (busy && !m_valid) begin
                    if (cke) gap_cnt++;
                end else if (!busy) begin
                    check("gap_cycles", gap_cnt, IFG);
                    track = 1'b0;
                end
            end
            if (start && !busy && cke) begin
                accepts++;
                push_frame();
            end
            if (m_valid && m_ready && cke) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %02h with no byte expected", m_data);
                end else begin
                    e = exp_q.pop_front();
                    check("m_data", 32'(m_data), 32'(e[7:0]));
                    check("m_first", 32'(m_first), 32'(e[9]));
                    check("m_last", 32'(m_last), 32'(e[8]));
                    check("packet_start", 32'(pkt_s), 32'(e[9]));
                    check("packet_finish", 32'(pkt_f), 32'(e[8]));
                end
                fbytes = m_first ? 1 : fbytes + 1;
                if (m_last) begin
                    frames_done++;
                    if (len_q.size() > 0) check("frame_len", fbytes, len_q.pop_front());
                    track   = 1'b1;
                    gap_cnt = 0;
                end
            end else begin
                check("pulse_idle", {30'd0, pkt_s, pkt_f}, 32'd0);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (pay_taken && pay_q.size() > 0) pay_q.delete(0);
        cke     = cke_toggle ? ~cke : 1'b1;
        m_ready = ($urandom_range(0, 99) < rdy_pct);
        s_valid = (pay_q.size() > 0) && ($urandom_range(0, 99) < val_pct);
        s_data  = (pay_q.size() > 0) ? pay_q[0] : 8'h00;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_frames(input int target, input string name);
        int n = 0;
        while (frames_done < target && n < 5000) begin
            tick();
            n++;
        end
        if (frames_done < target) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, frames %0d expected %0d", name, frames_done, target);
        end
    endtask

    task automatic issue(input string name);
        int a0 = accepts;
        int n  = 0;
        start = 1'b1;
        while (accepts == a0 && n < 2000) begin
            tick();
            n++;
        end
        start = 1'b0;
        if (accepts == a0) begin
            checks++;
            errors++;
            $display("FAIL %s: start not accepted, accepts %0d expected %0d", name, accepts, a0 + 1);
        end
    endtask

    initial begin
        logic [31:0] c;
        logic [7:0]  ch;
        int          f0, c0, n;
        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tbl[i] = c;
        end
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 9; i++) begin
            ch = 8'h31 + 8'(i);
            c  = crc_bytes(c, ch);
        end
        check("crc_model_vector", ~c, 32'hCBF43926);

        reset = 1'b1;
        repeat (3) tick();
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_s_ready", 32'(s_ready), 0);
        check("rst_m_first", 32'(m_first), 0);
        check("rst_m_last", 32'(m_last), 0);
        check("rst_pkt_start", 32'(pkt_s), 0);
        check("rst_pkt_finish", 32'(pkt_f), 0);
        reset = 1'b0;
        tick();

        // fixed frame with exact start latency
        p_mac_en = 1'b0; p_node = 8'h12; p_type = 8'h34; p_len = 16'd2; fixed_pay = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("lat_busy", 32'(busy), 1);
        check("lat_valid_early", 32'(m_valid), 0);
        tick();
        check("lat_valid", 32'(m_valid), 1);
        check("lat_first", 32'(m_first), 1);
        check("lat_data", 32'(m_data), 32'h55);
        wait_frames(1, "t1_frame");
        fixed_pay = 1'b0;

        // MAC header, empty payload
        p_mac_en = 1'b1; p_dst = 48'hFFFF_FFFF_FFFF; p_src = 48'h0011_2233_4455;
        p_mtype = 16'h88B5; p_node = 8'hA5; p_type = 8'h5A; p_len = 16'd0;
        issue("t2_start");
        wait_frames(frames_done + 1, "t2_frame");

        // throttled output and upstream
        rdy_pct = 60; val_pct = 50;
        for (int k = 0; k < 3; k++) begin
            p_mac_en = 1'($urandom); p_dst = {16'($urandom), 32'($urandom)};
            p_src = {16'($urandom), 32'($urandom)}; p_mtype = 16'($urandom);
            p_node = 8'($urandom); p_type = 8'($urandom); p_len = 16'd64;
            issue("t3_start");
            wait_frames(frames_done + 1, "t3_frame");
        end

        // start held high, params churning every cycle
        rdy_pct = 100; val_pct = 100;
        f0 = frames_done; n = 0;
        start = 1'b1;
        while (frames_done < f0 + 3 && n < 3000) begin
            p_mac_en = 1'($urandom); p_dst = {16'($urandom), 32'($urandom)};
            p_node = 8'($urandom); p_type = 8'($urandom);
            p_len = 16'($urandom_range(0, 6));
            tick();
            n++;
        end
        start = 1'b0;
        wait_frames(accepts, "t4_frames");
        check("t4_frame_count", (frames_done >= f0 + 3) ? 1 : 0, 1);

        // cke toggling every cycle with mild throttling
        cke_toggle = 1'b1; rdy_pct = 70; val_pct = 70;
        for (int k = 0; k < 2; k++) begin
            p_mac_en = 1'(k); p_len = 16'd10; p_node = 8'($urandom);
            issue("t5_start");
            wait_frames(frames_done + 1, "t5_frame");
        end
        cke_toggle = 1'b0; rdy_pct = 100; val_pct = 100;
        repeat (30) tick();

        // reset during payload
        p_mac_en = 1'b0; p_len = 16'd20;
        f0 = frames_done;
        issue("t6_start");
        c0 = consumed; n = 0;
        while (consumed < c0 + 3 && n < 500) begin
            tick();
            n++;
        end
        check("t6_reached_payload", (consumed >= c0 + 3) ? 1 : 0, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete(); len_q.delete(); pay_q.delete();
        check("t6_valid_after_reset", 32'(m_valid), 0);
        check("t6_busy_after_reset", 32'(busy), 0);
        tick();
        p_len = 16'd5; p_node = 8'h77;
        issue("t6_restart");
        wait_frames(f0 + 1, "t6_frame");
        repeat (20) tick();
        check("exp_q_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
